imm_gen_pipe: RTL and testbench

Parametrised, registered immediate generator for the RISC-V decode stage. It accepts an instruction word, an immediate-format select and an opaque tag over a valid/ready handshake. It produces the sign- or zero-extended XLEN-wide immediate one cycle later through a 2-entry output buffer, so that execute-stage backpressure does not break a 1-per-cycle throughput. It adds the CSR zimm and shamt formats, XLEN=64 support, and an illegal-select flag.

---
 rtl/imm_gen_pipe.sv | 159 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a 2-entry output
// buffer. Decodes I/S/B/J/U/Z(csr uimm)/shamt immediates to XLEN bits and
// flags the undefined select 3'b111. The head entry lives in its own register
// so the out_* ports keep their last values after the buffer drains.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_bad
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] SEL_I  = 3'b000;
    localparam logic [2:0] SEL_S  = 3'b001;
    localparam logic [2:0] SEL_B  = 3'b010;
    localparam logic [2:0] SEL_J  = 3'b011;
    localparam logic [2:0] SEL_U  = 3'b100;
    localparam logic [2:0] SEL_Z  = 3'b101;
    localparam logic [2:0] SEL_SH = 3'b110;

    // Sign-extending formats are built as signed 32-bit values and widened by
    // a signed size cast; zero-extending formats are built unsigned.
    function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] instr,
                                                   input logic [2:0]  sel);
        logic signed [31:0] s32;
        logic        [31:0] u32;
        logic        [XLEN-1:0] res;
        s32 = '0;
        u32 = '0;
        res = '0;
        case (sel)
            SEL_I:  begin s32 = {{20{instr[31]}}, instr[31:20]}; res = XLEN'(s32); end
            SEL_S:  begin s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]}; res = XLEN'(s32); end
            SEL_B:  begin
                s32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                res = XLEN'(s32);
            end
            SEL_J:  begin
                s32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                res = XLEN'(s32);
            end
            SEL_U:  begin s32 = {instr[31:12], 12'b0}; res = XLEN'(s32); end
            SEL_Z:  begin u32 = {27'b0, instr[19:15]}; res = XLEN'(u32); end
            SEL_SH: begin
                if (XLEN == 64) u32 = {26'b0, instr[25:20]};
                else            u32 = {27'b0, instr[24:20]};
                res = XLEN'(u32);
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic decode_illegal(input logic [2:0] sel);
        return (sel == 3'b111);
    endfunction

    logic [1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]  head_imm_q, head_imm_d;
    logic [TAG_W-1:0] head_tag_q, head_tag_d;
    logic             head_ill_q, head_ill_d;
    logic [XLEN-1:0]  spare_imm_q, spare_imm_d;
    logic [TAG_W-1:0] spare_tag_q, spare_tag_d;
    logic             spare_ill_q, spare_ill_d;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;
    logic             push, pop;

    assign dec_imm   = decode_imm(in_instr, in_sel);
    assign dec_ill   = decode_illegal(in_sel);

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm     = head_imm_q;
    assign out_tag     = head_tag_q;
    assign out_illegal = head_ill_q;

    // Next-state: new entries fill the head when it is free (or being popped
    // with one entry), otherwise the spare; a pop with two entries promotes
    // the spare. Head is untouched when the last entry pops.
    always_comb begin
        cnt_d       = cnt_q;
        head_imm_d  = head_imm_q;
        head_tag_d  = head_tag_q;
        head_ill_d  = head_ill_q;
        spare_imm_d = spare_imm_q;
        spare_tag_d = spare_tag_q;
        spare_ill_d = spare_ill_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_imm_d = dec_imm;
                    head_tag_d = in_tag;
                    head_ill_d = dec_ill;
                end else begin
                    spare_imm_d = dec_imm;
                    spare_tag_d = in_tag;
                    spare_ill_d = dec_ill;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_imm_d = spare_imm_q;
                    head_tag_d = spare_tag_q;
                    head_ill_d = spare_ill_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                head_imm_d = dec_imm;
                head_tag_d = in_tag;
                head_ill_d = dec_ill;
            end
            default: ;
        endcase
    end

    // Occupancy and head entry; reset clears both so outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 2'd0;
            head_imm_q <= '0;
            head_tag_q <= '0;
            head_ill_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            head_imm_q <= head_imm_d;
            head_tag_q <= head_tag_d;
            head_ill_q <= head_ill_d;
        end
    end

    // Spare entry data; only meaningful while occupancy is two.
    always_ff @(posedge clk) begin
        spare_imm_q <= spare_imm_d;
        spare_tag_q <= spare_tag_d;
        spare_ill_q <= spare_ill_d;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance
// driven with the same handshake stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_sel;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Present one instruction for one edge; returns #1 after that edge.
    task automatic push(input logic [2:0] sel, input logic [31:0] instr, input logic [4:0] tag);
        in_valid = 1'b1;
        in_sel   = sel;
        in_instr = instr;
        in_tag   = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Single transaction on the 32-bit instance, consumer always ready.
    task automatic one32(input string name, input logic [2:0] sel, input logic [31:0] instr,
                         input logic [31:0] exp_imm, input logic exp_ill);
        push(sel, instr, 5'd9);
        check({name, "_vld"}, {63'd0, out_valid32}, 64'd1);
        check({name, "_imm"}, {32'd0, out_imm32}, {32'd0, exp_imm});
        check({name, "_ill"}, {63'd0, out_illegal32}, {63'd0, exp_ill});
        tick();
    endtask

    task automatic one64(input string name, input logic [2:0] sel, input logic [31:0] instr,
                         input logic [63:0] exp_imm);
        push(sel, instr, 5'd10);
        check({name, "_vld"}, {63'd0, out_valid64}, 64'd1);
        check({name, "_imm"}, out_imm64, exp_imm);
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_sel = '0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_vld",   {63'd0, out_valid32}, 64'd0);
        check("rst_rdy",   {63'd0, in_ready32}, 64'd1);
        check("rst_imm",   {32'd0, out_imm32}, 64'd0);
        check("rst_tag",   {59'd0, out_tag32}, 64'd0);
        check("rst_ill",   {63'd0, out_illegal32}, 64'd0);
        check("rst_vld64", {63'd0, out_valid64}, 64'd0);

        // Format decode, XLEN=32
        one32("i32",  3'b000, 32'hFFF00093, 32'hFFFFFFFF, 1'b0);
        check("hold_empty_vld", {63'd0, out_valid32}, 64'd0);
        check("hold_empty_imm", {32'd0, out_imm32}, 64'h0000_0000_FFFF_FFFF);
        one32("s32",  3'b001, 32'hFE20AE23, 32'hFFFFFFFC, 1'b0);
        one32("b32",  3'b010, 32'hFE000EE3, 32'hFFFFFFFC, 1'b0);
        one32("j32",  3'b011, 32'hFF9FF06F, 32'hFFFFFFF8, 1'b0);
        one32("u32",  3'b100, 32'h123450B7, 32'h12345000, 1'b0);
        one32("z32",  3'b101, 32'h0002D073, 32'h00000005, 1'b0);
        one32("sh32", 3'b110, 32'h03F0D093, 32'h0000001F, 1'b0);
        one32("bad32",3'b111, 32'hFFFFFFFF, 32'h00000000, 1'b1);

        // Format decode, XLEN=64
        one64("i64",  3'b000, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF);
        one64("u64",  3'b100, 32'h800000B7, 64'hFFFFFFFF80000000);
        one64("sh64", 3'b110, 32'h03F0D093, 64'h000000000000003F);

        // Backpressure: tags 1,2 accepted, 3 held until drain
        out_ready = 1'b0;
        push(3'b000, 32'h00100093, 5'd1);
        check("bp_rdy1", {63'd0, in_ready32}, 64'd1);
        push(3'b000, 32'h00200093, 5'd2);
        check("bp_rdy2", {63'd0, in_ready32}, 64'd0);
        check("bp_head", {59'd0, out_tag32}, 64'd1);
        in_valid = 1'b1; in_sel = 3'b000; in_instr = 32'h00300093; in_tag = 5'd3;
        tick();
        check("bp_stall_rdy", {63'd0, in_ready32}, 64'd0);
        check("bp_stall_tag", {59'd0, out_tag32}, 64'd1);
        check("bp_stall_imm", {32'd0, out_imm32}, 64'd1);
        out_ready = 1'b1;
        tick();
        check("drain_t2",   {59'd0, out_tag32}, 64'd2);
        check("drain_i2",   {32'd0, out_imm32}, 64'd2);
        check("drain_rdy",  {63'd0, in_ready32}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("drain_t3",   {59'd0, out_tag32}, 64'd3);
        check("drain_v3",   {63'd0, out_valid32}, 64'd1);
        check("drain_i3",   {32'd0, out_imm32}, 64'd3);
        tick();
        check("drain_empty", {63'd0, out_valid32}, 64'd0);

        // Sustained 1-per-cycle throughput
        in_valid = 1'b1; in_sel = 3'b000;
        for (int k = 0; k < 3; k++) begin
            in_tag = 5'(4 + k);
            in_instr = {12'(4 + k), 20'h00093};
            tick();
            check("thru_tag", {59'd0, out_tag32}, 64'(4 + k));
            check("thru_vld", {63'd0, out_valid32}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("thru_end", {63'd0, out_valid32}, 64'd0);

        // Reset with two entries held, overriding a presented input
        out_ready = 1'b0;
        push(3'b001, 32'hFE20AE23, 5'd7);
        push(3'b001, 32'hFE20AE23, 5'd8);
        check("pre_rst_rdy", {63'd0, in_ready32}, 64'd0);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("mid_rst_vld", {63'd0, out_valid32}, 64'd0);
        check("mid_rst_rdy", {63'd0, in_ready32}, 64'd1);
        check("mid_rst_imm", {32'd0, out_imm32}, 64'd0);
        check("mid_rst_tag", {59'd0, out_tag32}, 64'd0);
        push(3'b100, 32'h123450B7, 5'd11);
        check("post_rst_vld", {63'd0, out_valid32}, 64'd1);
        check("post_rst_imm", {32'd0, out_imm32}, 64'h12345000);
        check("post_rst_tag", {59'd0, out_tag32}, 64'd11);
        tick();
        check("post_rst_alone", {63'd0, out_valid32}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
